// File: rtl/axi_line_fill_bridge_if.sv
// Bundle of the cache-side line-fill port and the AXI4 read-address/read-data channels.
// The slave modport is the bridge's view; the master modport is the cache + interconnect side.
interface axi_line_fill_bridge_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BEAT_W = 32;
    localparam int unsigned LINE_W = 256;

    // Cache-side sram-like line-fill port
    logic              line_req;
    logic              line_wr;
    logic [1:0]        line_size;
    logic [ADDR_W-1:0] line_addr;
    logic [BEAT_W-1:0] line_wdata;
    logic [LINE_W-1:0] line_rdata;
    logic              line_addr_ok;
    logic              line_data_ok;
    logic              line_err;

    // AXI4 read address channel
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    // AXI4 read data channel
    logic [3:0]        rid;
    logic [BEAT_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  line_req, line_wr, line_size, line_addr, line_wdata,
        output line_rdata, line_addr_ok, line_data_ok, line_err,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport master (
        output line_req, line_wr, line_size, line_addr, line_wdata,
        input  line_rdata, line_addr_ok, line_data_ok, line_err,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_line_fill_bridge.sv
// I-cache line-fill responder: turns one 32-byte line request into an 8-beat
// AXI4 INCR read burst and returns the packed 256-bit line with a single pulse.
module axi_line_fill_bridge #(
    parameter logic [3:0] ARID = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_line_fill_bridge_if.slave bus
);
    localparam int unsigned BEATS  = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BEAT_W = 32;
    localparam int unsigned OFF_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic [BEATS-1:0][BEAT_W-1:0] buf_q, buf_d;
    logic [31:0]                 araddr_q, araddr_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic                        data_ok_q, data_ok_d;
    logic                        line_err_q, line_err_d;

    logic accept_c;
    logic beat_c;
    logic last_beat_c;
    logic beat_err_c;
    logic unused_c;

    // Request acceptance and per-beat qualifiers
    assign accept_c    = (state_q == ST_IDLE) && bus.line_req && !bus.line_wr;
    assign beat_c      = (state_q == ST_R) && bus.rvalid;
    assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));
    assign beat_err_c  = (bus.rresp != 2'b00) || (bus.rlast != last_beat_c);

    // Fields the line fill never looks at
    assign unused_c = ^{bus.line_size, bus.line_wdata, bus.rid, bus.line_addr[OFF_W-1:0]};

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        buf_d      = buf_q;
        araddr_d   = araddr_q;
        line_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    araddr_d = {bus.line_addr[31:OFF_W], OFF_W'(0)};
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = ST_AR;
                end
            end
            ST_AR: begin
                // arvalid is high for the whole AR state, so arready alone completes it
                if (bus.arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (beat_c) begin
                    buf_d[cnt_q] = bus.rdata;
                    cnt_d        = cnt_q + CNT_W'(1);
                    err_d        = err_q | beat_err_c;
                    // Eighth beat ends the burst whatever rlast says
                    if (last_beat_c) begin
                        state_d    = ST_DONE;
                        line_err_d = err_q | beat_err_c;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arvalid_d = (state_d == ST_AR);
        rready_d  = (state_d == ST_R);
        data_ok_d = (state_d == ST_DONE);
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            buf_q      <= '0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            data_ok_q  <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            buf_q      <= buf_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            data_ok_q  <= data_ok_d;
            line_err_q <= line_err_d;
        end
    end

    assign bus.line_addr_ok = accept_c;
    assign bus.line_data_ok = data_ok_q;
    assign bus.line_err     = line_err_q;
    assign bus.line_rdata   = buf_q;

    assign bus.arid    = ARID;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'd7;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;
endmodule
